// File: rtl/uart_rx_os16.sv
// UART receive end with an internal 16x oversampling tick on a single system clock.
// Frame format: start bit, Data_length data bits LSB first, optional parity bit, one stop bit.
module uart_rx_os16 #(
   parameter int unsigned Data_length = 8,
   parameter int unsigned parity_en   = 0,
   parameter int unsigned CLK_DIV     = 4
) (
   input  logic                   rx_clk,
   input  logic                   rst,
   input  logic                   serialdata_in,
   input  logic                   parity_type,
   output logic [Data_length-1:0] parallel_dataout,
   output logic                   rx_done,
   output logic                   parity_error,
   output logic                   frame_error,
   output logic                   busy
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [2:0] BitLast = 3'(Data_length - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_e;

   state_e                 state_q, state_d;
   logic                   sync1_q, sync2_q, prev_q;
   logic [DivW-1:0]        div_q, div_d;
   logic [3:0]             tcnt_q, tcnt_d;
   logic [2:0]             bit_q, bit_d;
   logic [Data_length-1:0] shift_q, shift_d;
   logic                   par_q, par_d;
   logic [Data_length-1:0] dout_q, dout_d;
   logic                   done_q, done_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   line, tick, mid_bit;

   assign line    = sync2_q;
   assign tick    = (state_q != StIdle) && (div_q == DivLast);
   assign mid_bit = tick && (tcnt_q == 4'd15);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      tcnt_d  = tcnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      perr_d  = perr_q;
      ferr_d  = ferr_q;

      // The divider only runs while a frame is in progress.
      if (state_q != StIdle) begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick) tcnt_d = tcnt_q + 4'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (prev_q && !line) begin
               state_d = StStart;
               div_d   = '0;
               tcnt_d  = '0;
               bit_d   = '0;
            end
         end
         StStart: begin
            if (tick && tcnt_q == 4'd7) begin
               tcnt_d  = '0;
               state_d = line ? StIdle : StData;
            end
         end
         StData: begin
            if (mid_bit) begin
               shift_d = {line, shift_q[Data_length-1:1]};
               if (bit_q == BitLast) begin
                  bit_d   = '0;
                  state_d = (parity_en != 0) ? StParity : StStop;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         StParity: begin
            if (mid_bit) begin
               par_d   = (^shift_q) ^ line ^ parity_type;
               state_d = StStop;
            end
         end
         StStop: begin
            if (mid_bit) begin
               dout_d  = shift_q;
               done_d  = 1'b1;
               perr_d  = (parity_en != 0) ? par_q : 1'b0;
               ferr_d  = !line;
               state_d = line ? StIdle : StWaitHigh;
            end
         end
         StWaitHigh: begin
            if (line) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge rx_clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= StIdle;
         div_q   <= '0;
         tcnt_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= serialdata_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         div_q   <= div_d;
         tcnt_q  <= tcnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   assign parallel_dataout = dout_q;
   assign rx_done          = done_q;
   assign parity_error     = perr_q;
   assign frame_error      = ferr_q;
   assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: an 8N1 instance and an 8-bit parity instance, driven with
// directed and random frames and checked against a frame-level expectation queue.
`timescale 1ns/1ps
module tb_uart_rx_os16;

   localparam int unsigned N   = 8;
   localparam int unsigned DIV = 4;
   localparam int unsigned BIT = 16 * DIV;
   localparam int unsigned TOL = DIV + 4;

   typedef struct {
      logic [7:0]  data;
      logic        perr;
      logic        ferr;
      int unsigned t0;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line_a = 1'b1, line_b = 1'b1, ptype_b = 1'b0;
   logic [7:0] dout_a, dout_b;
   logic       done_a, done_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

   exp_t        q_a[$];
   exp_t        q_b[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   logic        rst_p = 1'b1;
   int          done_cnt[2] = '{0, 0};
   int unsigned last_lat[2] = '{0, 0};
   logic [7:0]  last_d[2];
   logic        last_pe[2];
   logic        last_fe[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rst_p <= rst;

   uart_rx_os16 #(.Data_length(N), .parity_en(0), .CLK_DIV(DIV)) dut_a (
      .rx_clk(clk), .rst(rst), .serialdata_in(line_a), .parity_type(1'b0),
      .parallel_dataout(dout_a), .rx_done(done_a), .parity_error(perr_a),
      .frame_error(ferr_a), .busy(busy_a)
   );

   uart_rx_os16 #(.Data_length(N), .parity_en(1), .CLK_DIV(DIV)) dut_b (
      .rx_clk(clk), .rst(rst), .serialdata_in(line_b), .parity_type(ptype_b),
      .parallel_dataout(dout_b), .rx_done(done_b), .parity_error(perr_b),
      .frame_error(ferr_b), .busy(busy_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic setline(input int ch, input logic v);
      if (ch == 0) line_a = v;
      else line_b = v;
   endtask

   // Drives one frame on channel ch and queues what the receiver must report for it.
   task automatic send(input int ch, input logic [7:0] d, input logic pbit, input logic stop,
                       input logic ptype);
      logic bits[11];
      int   nb;
      exp_t e;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = d[i];
      nb = 9;
      if (ch == 1) begin
         bits[9] = pbit;
         nb = 10;
      end
      bits[nb] = stop;
      nb++;
      e.data = d;
      e.perr = (ch == 1) ? ((($countones(d) + int'(pbit)) % 2) != int'(ptype)) : 1'b0;
      e.ferr = !stop;
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         if (i == 0) begin
            if (ch == 1) ptype_b = ptype;
            e.t0 = cyc;
            if (ch == 0) q_a.push_back(e);
            else q_b.push_back(e);
         end
         setline(ch, bits[i]);
         repeat (BIT - 1) @(negedge clk);
      end
   endtask

   task automatic check_ch(input int ch, input logic done, input logic [7:0] d, input logic pe,
                           input logic fe);
      exp_t        e;
      bit          have;
      int unsigned lat, lreq;
      if (done) begin
         have = (ch == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
         chk($sformatf("ch%0d rx_done expected", ch), 32'(have), 32'd1);
         if (have) begin
            if (ch == 0) e = q_a.pop_front();
            else e = q_b.pop_front();
            last_d[ch]  = e.data;
            last_pe[ch] = e.perr;
            last_fe[ch] = e.ferr;
            lat  = cyc - e.t0;
            lreq = 2 + (16 * (1 + N + ((ch == 1) ? 1 : 0)) + 8) * DIV;
            last_lat[ch] = lat;
            chk($sformatf("ch%0d latency %0d near %0d", ch, lat, lreq),
                32'(lat + TOL >= lreq && lat <= lreq + TOL), 32'd1);
         end
         done_cnt[ch]++;
      end
      chk($sformatf("ch%0d dataout", ch), 32'(d), 32'(last_d[ch]));
      chk($sformatf("ch%0d parity_error", ch), 32'(pe), 32'(last_pe[ch]));
      chk($sformatf("ch%0d frame_error", ch), 32'(fe), 32'(last_fe[ch]));
   endtask

   // Per-cycle compare against the frame-level model.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_p) begin
            q_a.delete();
            q_b.delete();
            for (int c = 0; c < 2; c++) begin
               last_d[c]  = 8'h00;
               last_pe[c] = 1'b0;
               last_fe[c] = 1'b0;
            end
            chk("reset outputs a", {dout_a, done_a, perr_a, ferr_a, busy_a}, 32'd0);
            chk("reset outputs b", {dout_b, done_b, perr_b, ferr_b, busy_b}, 32'd0);
         end else begin
            check_ch(0, done_a, dout_a, perr_a, ferr_a);
            check_ch(1, done_b, dout_b, perr_b, ferr_b);
         end
      end
   end

   initial begin
      int  base;
      bit  seen;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // 8N1 character
      send(0, 8'hA5, 1'b0, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      chk("A5 data", 32'(dout_a), 32'h A5);
      chk("A5 errors", {perr_a, ferr_a}, 32'd0);
      chk("A5 busy after", 32'(busy_a), 32'd0);
      chk("A5 single strobe", 32'(done_cnt[0]), 32'd1);
      chk("A5 latency window", 32'(last_lat[0] >= 604 && last_lat[0] <= 616), 32'd1);

      // Parity: even good, even bad, odd good
      send(1, 8'h3C, 1'b0, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      chk("3C even p0 data", 32'(dout_b), 32'h3C);
      chk("3C even p0 perr", 32'(perr_b), 32'd0);
      send(1, 8'h3C, 1'b1, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      chk("3C even p1 perr", 32'(perr_b), 32'd1);
      chk("3C even p1 data", 32'(dout_b), 32'h3C);
      send(1, 8'h3C, 1'b1, 1'b1, 1'b1);
      repeat (8) @(negedge clk);
      chk("3C odd p1 perr", 32'(perr_b), 32'd0);

      // Glitch on the idle line
      base = done_cnt[0];
      seen = 1'b0;
      fork
         begin
            @(negedge clk);
            line_a = 1'b0;
            repeat (20) @(negedge clk);
            line_a = 1'b1;
         end
         begin
            repeat (40) begin
               @(negedge clk);
               if (busy_a) seen = 1'b1;
            end
         end
      join
      repeat (100) @(negedge clk);
      chk("glitch busy rose", 32'(seen), 32'd1);
      chk("glitch busy fell", 32'(busy_a), 32'd0);
      chk("glitch no strobe", 32'(done_cnt[0] - base), 32'd0);
      chk("glitch data kept", 32'(dout_a), 32'h A5);

      // Framing error with a held break, then recovery
      base = done_cnt[0];
      send(0, 8'h55, 1'b0, 1'b0, 1'b0);
      repeat (300) @(negedge clk);
      line_a = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      chk("break single strobe", 32'(done_cnt[0] - base), 32'd1);
      chk("break data", 32'(dout_a), 32'h55);
      chk("break frame_error", 32'(ferr_a), 32'd1);
      chk("break busy after", 32'(busy_a), 32'd0);
      send(0, 8'h12, 1'b0, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      chk("12 data", 32'(dout_a), 32'h12);
      chk("12 frame_error", 32'(ferr_a), 32'd0);

      // Reset during data bit 3
      base = done_cnt[0];
      fork
         send(0, 8'hFF, 1'b0, 1'b1, 1'b0);
         begin
            repeat (BIT * 4 + BIT / 2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      join
      repeat (8) @(negedge clk);
      chk("rst abort no strobe", 32'(done_cnt[0] - base), 32'd0);
      chk("rst abort outputs", {dout_a, perr_a, ferr_a, busy_a}, 32'd0);
      send(0, 8'h81, 1'b0, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      chk("81 data", 32'(dout_a), 32'h81);

      // Back-to-back frames
      base = done_cnt[0];
      send(0, 8'h00, 1'b0, 1'b1, 1'b0);
      send(0, 8'hFF, 1'b0, 1'b1, 1'b0);
      send(0, 8'h5A, 1'b0, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      chk("b2b count", 32'(done_cnt[0] - base), 32'd3);
      chk("b2b last data", 32'(dout_a), 32'h5A);

      // Random traffic on both channels, gaps including zero
      for (int k = 0; k < 30; k++) begin
         fork
            begin
               automatic logic [7:0] d = 8'($urandom);
               automatic int g = $urandom_range(0, 40);
               repeat (g) @(negedge clk);
               send(0, d, 1'b0, 1'b1, 1'b0);
            end
            begin
               automatic logic [7:0] d2 = 8'($urandom);
               automatic logic pb = 1'($urandom);
               automatic logic pt = 1'($urandom);
               automatic int g2 = $urandom_range(0, 40);
               repeat (g2) @(negedge clk);
               send(1, d2, pb, 1'b1, pt);
            end
         join
      end
      repeat (2 * BIT) @(negedge clk);
      chk("ch0 frames all received", 32'(q_a.size()), 32'd0);
      chk("ch1 frames all received", 32'(q_b.size()), 32'd0);
      chk("final busy", {busy_a, busy_b}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
